// File: rtl/free_list.sv
// free_list: physical register free list, 16-entry circular FIFO of free ids plus a free bitmap.
// Optional same-cycle retire-to-allocate bypass when empty: define FREE_LIST_BYPASS_EN.
module free_list #(
    parameter int ARCH_REGS = 8,
    parameter int PRF_SIZE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       retire_transmit,
    input  logic [3:0] retire_id,
    input  logic       alloc_req,
    output logic       alloc_valid,
    output logic [3:0] alloc_id,
    output logic [4:0] free_count,
    output logic       double_free_err,
    output logic       overflow_err
);
    logic [3:0]  fifo [PRF_SIZE];
    logic [3:0]  head, tail;
    logic [15:0] bitmap, bitmap_popped;
    logic        pop, dbl, full, push, bypass_offer;

    // Decide pop/push for this edge; the pop's bitmap clear is applied before the double-free test
    always_comb begin
        pop           = alloc_req && free_count != 5'd0;
        bitmap_popped = bitmap & ~(pop ? 16'd1 << fifo[head] : 16'd0);
        dbl           = retire_transmit && bitmap_popped[retire_id];
        full          = free_count == 5'(PRF_SIZE);
`ifdef FREE_LIST_BYPASS_EN
        bypass_offer  = retire_transmit && !dbl && free_count == 5'd0;
`else
        bypass_offer  = 1'b0;
`endif
        alloc_valid   = free_count != 5'd0 || bypass_offer;
        alloc_id      = bypass_offer ? retire_id : fifo[head];
        push          = retire_transmit && !dbl && !full && !(bypass_offer && alloc_req);
    end

    // FIFO, pointers, count, bitmap and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) fifo[i] <= 4'(ARCH_REGS + i);
            head            <= '0;
            tail            <= 4'(PRF_SIZE - ARCH_REGS);
            free_count      <= 5'(PRF_SIZE - ARCH_REGS);
            bitmap          <= ~((16'd1 << ARCH_REGS) - 16'd1);
            double_free_err <= 1'b0;
            overflow_err    <= 1'b0;
        end else begin
            if (push) fifo[tail] <= retire_id;
            head            <= head + 4'(pop);
            tail            <= tail + 4'(push);
            free_count      <= free_count + 5'(push) - 5'(pop);
            bitmap          <= push ? bitmap_popped | (16'd1 << retire_id) : bitmap_popped;
            double_free_err <= double_free_err | dbl;
            overflow_err    <= overflow_err | (retire_transmit && !dbl && full);
        end
    end
endmodule
